// File: rtl/cpu_alu.sv
// Registered 32-bit ALU with Z/N/C/V/S/H flags; ALU_SHIFT_EN enables SL/SR.
// Latency: one cycle, result and flags update together on rising clk.
// Backpressure: none, accepts a new op every cycle; undefined opcodes hold state.
module cpu_alu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [7:0]  op,
    output logic [31:0] out,
    output logic        zflag,
    output logic        nflag,
    output logic        cflag,
    output logic        vflag,
    output logic        sflag,
    output logic        hflag
);

    localparam logic [7:0] OP_LD  = 8'h01;
    localparam logic [7:0] OP_ADD = 8'h03;
    localparam logic [7:0] OP_SUB = 8'h04;
    localparam logic [7:0] OP_AND = 8'h05;
    localparam logic [7:0] OP_OR  = 8'h06;
    localparam logic [7:0] OP_XOR = 8'h07;
    localparam logic [7:0] OP_NOT = 8'h08;
`ifdef ALU_SHIFT_EN
    localparam logic [7:0] OP_SL  = 8'h09;
    localparam logic [7:0] OP_SR  = 8'h0A;
`endif

    logic [32:0] sum;
    logic [4:0]  hsum;
    logic [31:0] diff;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign hsum = {1'b0, a[3:0]} + {1'b0, b[3:0]};
    assign diff = a - b;

`ifdef ALU_SHIFT_EN
    // Extra guard bit catches the last bit shifted out; shifts >= width yield zero.
    logic [32:0] shl;
    logic [32:0] shr;
    assign shl = {1'b0, a} << b;
    assign shr = {a, 1'b0} >> b;
`endif

    logic [31:0] nxt_out;
    logic        nxt_c;
    logic        nxt_v;
    logic        nxt_h;
    logic        upd;

    always_comb begin
        nxt_out = out;
        nxt_c   = 1'b0;
        nxt_v   = 1'b0;
        nxt_h   = 1'b0;
        upd     = 1'b1;
        case (op)
            OP_LD:  nxt_out = b;
            OP_ADD: begin
                nxt_out = sum[31:0];
                nxt_c   = sum[32];
                nxt_h   = hsum[4];
                nxt_v   = (a[31] == b[31]) && (sum[31] != a[31]);
            end
            OP_SUB: begin
                nxt_out = diff;
                nxt_c   = a < b;
                nxt_h   = a[3:0] < b[3:0];
                nxt_v   = (a[31] != b[31]) && (diff[31] != a[31]);
            end
            OP_AND: nxt_out = a & b;
            OP_OR:  nxt_out = a | b;
            OP_XOR: nxt_out = a ^ b;
            OP_NOT: nxt_out = ~a;
`ifdef ALU_SHIFT_EN
            OP_SL: begin
                nxt_out = shl[31:0];
                nxt_c   = shl[32];
            end
            OP_SR: begin
                nxt_out = shr[32:1];
                nxt_c   = shr[0];
            end
`endif
            default: upd = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out   <= '0;
            zflag <= 1'b0;
            nflag <= 1'b0;
            cflag <= 1'b0;
            vflag <= 1'b0;
            sflag <= 1'b0;
            hflag <= 1'b0;
        end else if (upd) begin
            out   <= nxt_out;
            zflag <= (nxt_out == 32'd0);
            nflag <= nxt_out[31];
            cflag <= nxt_c;
            vflag <= nxt_v;
            sflag <= nxt_out[31] ^ nxt_v;
            hflag <= nxt_h;
        end
    end

endmodule

// File: tb/tb_cpu_alu.sv
// Scoreboard bench for cpu_alu: driver queues hand-computed results, monitor compares.
module tb_cpu_alu;

    logic        clk;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] b;
    logic [7:0]  op;
    logic [31:0] out;
    logic        zflag, nflag, cflag, vflag, sflag, hflag;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_out_q[$];
    logic [5:0]  exp_flg_q[$];
    string       name_q[$];

    cpu_alu dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .op    (op),
        .out   (out),
        .zflag (zflag),
        .nflag (nflag),
        .cflag (cflag),
        .vflag (vflag),
        .sflag (sflag),
        .hflag (hflag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] flags_now();
        return {zflag, nflag, cflag, vflag, sflag, hflag};
    endfunction

    task automatic check(input string nm, input logic [31:0] eo, input logic [5:0] ef);
        checks++;
        if (out !== eo) begin
            failures++;
            $display("FAIL %s out: got %08h expected %08h", nm, out, eo);
        end
        checks++;
        if (flags_now() !== ef) begin
            failures++;
            $display("FAIL %s flags(znvcsh order z,n,c,v,s,h): got %06b expected %06b",
                     nm, flags_now(), ef);
        end
    endtask

    // Monitor: every op issued on a negedge produces its result at the following posedge.
    always @(posedge clk) begin
        #1;
        if (exp_out_q.size() > 0) begin
            logic [31:0] eo;
            logic [5:0]  ef;
            string       nm;
            eo = exp_out_q.pop_front();
            ef = exp_flg_q.pop_front();
            nm = name_q.pop_front();
            check(nm, eo, ef);
        end
    end

    // Flags are {z,n,c,v,s,h}.
    task automatic issue(input string nm, input logic [7:0] top, input logic [31:0] ta,
                         input logic [31:0] tb_v, input logic [31:0] eo, input logic [5:0] ef);
        @(negedge clk);
        a  = ta;
        b  = tb_v;
        op = top;
        exp_out_q.push_back(eo);
        exp_flg_q.push_back(ef);
        name_q.push_back(nm);
    endtask

    task automatic idle();
        @(negedge clk);
        op = 8'h00;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_out_q.size() > 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (exp_out_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d results still pending, expected 0", exp_out_q.size());
            exp_out_q.delete();
            exp_flg_q.delete();
            name_q.delete();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        a     = '0;
        b     = '0;
        op    = 8'h00;
        #12;
        check("reset_init", 32'h0, 6'b000000);
        @(negedge clk);
        rst_n = 1'b1;

        issue("ld5",      8'h01, 32'h0,        32'h5,        32'h00000005, 6'b000000);
        issue("add_c",    8'h03, 32'hFFFFFFFF, 32'h1,        32'h00000000, 6'b101001);
        issue("add_v",    8'h03, 32'h7FFFFFFF, 32'h1,        32'h80000000, 6'b010101);
        issue("sub1",     8'h04, 32'hFFFFFFF8, 32'h1,        32'hFFFFFFF7, 6'b010010);
        issue("sub_brw",  8'h04, 32'h0,        32'h1,        32'hFFFFFFFF, 6'b011011);
        issue("and",      8'h05, 32'h12345678, 32'h87654321, 32'h02244220, 6'b000000);
        issue("or",       8'h06, 32'hF0,       32'h0F,       32'h000000FF, 6'b000000);
        issue("xor",      8'h07, 32'hF0,       32'h0F,       32'h000000FF, 6'b000000);
        issue("not",      8'h08, 32'hF0,       32'h0,        32'hFFFFFF0F, 6'b010010);
        issue("undef02",  8'h02, 32'h1,        32'h2,        32'hFFFFFF0F, 6'b010010);
`ifdef ALU_SHIFT_EN
        issue("sl3",      8'h09, 32'hFFFF,     32'd3,        32'h0007FFF8, 6'b000000);
        issue("sr3",      8'h0A, 32'hFFFF,     32'd3,        32'h00001FFF, 6'b001000);
        issue("sr40",     8'h0A, 32'hFFFF,     32'd40,       32'h00000000, 6'b100000);
        issue("sl0",      8'h09, 32'h80000001, 32'd0,        32'h80000001, 6'b010010);
        issue("sl32",     8'h09, 32'h00000001, 32'd32,       32'h00000000, 6'b101000);
        issue("sr32",     8'h0A, 32'h80000000, 32'd32,       32'h00000000, 6'b101000);
        issue("sl33",     8'h09, 32'hFFFFFFFF, 32'd33,       32'h00000000, 6'b100000);
        issue("sr1",      8'h0A, 32'h00000003, 32'd1,        32'h00000001, 6'b001000);
`else
        issue("sl_hold",  8'h09, 32'hFFFF,     32'd3,        32'hFFFFFF0F, 6'b010010);
        issue("sr_hold",  8'h0A, 32'hFFFF,     32'd3,        32'hFFFFFF0F, 6'b010010);
`endif
        issue("ld_nz",    8'h01, 32'h0,        32'h12345678, 32'h12345678, 6'b000000);
        issue("undefFF",  8'hFF, 32'h0,        32'h0,        32'h12345678, 6'b000000);
        issue("undef00",  8'h00, 32'h0,        32'h0,        32'h12345678, 6'b000000);
        issue("add_h",    8'h03, 32'h0000000F, 32'h1,        32'h00000010, 6'b000001);
        issue("sub_h",    8'h04, 32'h00000010, 32'h1,        32'h0000000F, 6'b000001);
        issue("add_nv",   8'h03, 32'h80000000, 32'h80000000, 32'h00000000, 6'b101110);
        issue("sub_v",    8'h04, 32'h80000000, 32'h1,        32'h7FFFFFFF, 6'b000111);
        idle();
        drain();

        // Asynchronous reset away from any clock edge.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_async", 32'h0, 6'b000000);
        @(negedge clk);
        rst_n = 1'b1;
        issue("ld5_post", 8'h01, 32'h0, 32'h5, 32'h00000005, 6'b000000);
        idle();
        drain();
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
